fetch_sequencer: RTL and testbench

//  Owns the architectural PC and sequences instruction fetch for the multi-cycle core.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, fetch stride,
// default reset vector and the word-alignment check.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_OK         = 2'b00;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == ALIGN_OK;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Architectural PC owner and single-outstanding instruction fetch sequencer.
// Buffers one fetched word for decode and handles redirects and misaligned targets.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        misalign_fault
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  if_instr_next, if_pc_next;
  logic         if_valid_next, fault_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_REQ;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_instr       <= 32'd0;
      if_pc          <= 32'd0;
      misalign_fault <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      if_valid       <= if_valid_next;
      if_instr       <= if_instr_next;
      if_pc          <= if_pc_next;
      misalign_fault <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    if_valid_next = if_valid;
    if_instr_next = if_instr;
    if_pc_next    = if_pc;
    fault_next    = misalign_fault;

    case (state)
      ST_REQ: begin
        if (imem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if_instr_next = imem_resp_data;
          if_pc_next    = pc;
          if_valid_next = 1'b1;
          pc_next       = pc + INSTR_BYTES;
          state_next    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (if_ready) begin
          if_valid_next = 1'b0;
          state_next    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) state_next = ST_REQ;
      end
      ST_HALT: begin
        if_valid_next = 1'b0;
      end
      default: state_next = ST_REQ;
    endcase

    // Redirect overrides everything above; any word captured this cycle is dropped.
    if (redirect_valid) begin
      if_valid_next = 1'b0;
      if_instr_next = if_instr;
      if_pc_next    = if_pc;
      if (!is_aligned(redirect_pc)) begin
        fault_next = 1'b1;
        pc_next    = pc;
        state_next = ST_HALT;
      end else begin
        fault_next = 1'b0;
        pc_next    = redirect_pc;
        case (state)
          ST_REQ:   state_next = imem_req_ready  ? ST_DRAIN : ST_REQ;
          ST_WAIT:  state_next = imem_resp_valid ? ST_REQ   : ST_DRAIN;
          // The stale response may land in the same cycle as a second redirect;
          // leave DRAIN then, since no further response will arrive.
          ST_DRAIN: state_next = imem_resp_valid ? ST_REQ   : ST_DRAIN;
          default:  state_next = ST_REQ;
        endcase
      end
    end
  end

  // rst gating keeps the request low for every cycle reset is held.
  assign imem_req_valid = (state == ST_REQ) && !rst;
  assign imem_req_addr  = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: imem responder model, request and
// fetch queues checked by negedge monitors, plus directed state checks.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;
  int resp_delay = 0;
  int cycle_count = 0;
  int consume_cycles[$];
  logic [31:0] exp_req[$];
  fetch_t      exp_fetch[$];
  logic [31:0] mon_addr;
  fetch_t      mon_fetch;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count++;

  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  function automatic fetch_t mkFetch(input logic [31:0] addr);
    fetch_t f;
    f.pc    = addr;
    f.instr = instrFor(addr);
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic ifr,
                               input logic rv, input logic [31:0] rpc);
    rst            = r;
    imem_req_ready = rdy;
    if_ready       = ifr;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic waitFetchEmpty(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_fetch.size() != 0 && n < budget);
    if (exp_fetch.size() != 0) begin
      failNote("fetch_timeout", $sformatf("got %0d fetches outstanding, expected 0", exp_fetch.size()));
      exp_fetch.delete();
    end
  endtask

  task automatic waitAccept(input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) seen = 1;
      n++;
    end
    if (!seen) failNote("accept_timeout", "got no accepted request, expected one");
    tick();
  endtask

  task automatic waitIfValid(input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (if_valid) seen = 1;
      n++;
    end
    if (!seen) failNote("ifvalid_timeout", "got if_valid=0 throughout, expected 1");
  endtask

  // imem responder: accepts at most one request, answers resp_delay cycles later.
  initial begin
    logic        acc, rst_s, pending;
    logic [31:0] acc_addr, pend_addr;
    int          acc_delay, cnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    pending   = 1'b0;
    pend_addr = 32'd0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      acc       = imem_req_valid && imem_req_ready && !rst;
      acc_addr  = imem_req_addr;
      acc_delay = resp_delay;
      rst_s     = rst;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst_s) begin
        pending = 1'b0;
      end else begin
        if (acc) begin
          pending   = 1'b1;
          pend_addr = acc_addr;
          cnt       = acc_delay;
        end
        if (pending) begin
          if (cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instrFor(pend_addr);
            pending         = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Request monitor: every accepted request must match the next expected address.
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      if (exp_req.size() == 0) begin
        failNote("unexpected_req", $sformatf("got request 0x%08h, expected none", imem_req_addr));
      end else begin
        mon_addr = exp_req.pop_front();
        checkOutput("req_addr", imem_req_addr, mon_addr);
      end
    end
  end

  // Fetch monitor: a consumed instruction (not squashed by a redirect) is scored.
  always @(negedge clk) begin
    if (if_valid && if_ready && !redirect_valid) begin
      consume_cycles.push_back(cycle_count);
      if (exp_fetch.size() == 0) begin
        failNote("unexpected_fetch", $sformatf("got pc 0x%08h, expected none", if_pc));
      end else begin
        mon_fetch = exp_fetch.pop_front();
        checkOutput("if_pc", if_pc, mon_fetch.pc);
        checkOutput("if_instr", if_instr, mon_fetch.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    checkOutput("rst_fault", {31'd0, misalign_fault}, 32'd0);

    // Sequential fetch with zero-wait imem and an always-ready decode.
    tick();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    exp_fetch.push_back(mkFetch(32'h0));
    exp_fetch.push_back(mkFetch(32'h4));
    exp_fetch.push_back(mkFetch(32'h8));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);
    waitFetchEmpty(30);
    checkOutput("consume_count", 32'(consume_cycles.size()), 32'd3);
    if (consume_cycles.size() >= 3) begin
      checkOutput("throughput_gap1", 32'(consume_cycles[1] - consume_cycles[0]), 32'd3);
      checkOutput("throughput_gap2", 32'(consume_cycles[2] - consume_cycles[1]), 32'd3);
    end

    // Decode stalls: the buffered word must hold and no request may issue.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    waitIfValid(20);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      checkOutput("hold_if_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("hold_if_pc", if_pc, 32'hC);
      checkOutput("hold_if_instr", if_instr, instrFor(32'hC));
      checkOutput("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    exp_fetch.push_back(mkFetch(32'hC));
    exp_req.push_back(32'h10);
    resp_delay = 3;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect while the response for 0x10 is still outstanding.
    waitAccept(20);
    resp_delay = 0;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_fetch.push_back(mkFetch(32'h100));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("drain_if_valid", {31'd0, if_valid}, 32'd0);
    waitFetchEmpty(30);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect in HOLD with if_ready high: the word is squashed, not consumed.
    waitIfValid(20);
    tick();
    exp_req.push_back(32'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("squash_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("squash_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("squash_req_addr", imem_req_addr, 32'h200);
    tick();
    exp_fetch.push_back(mkFetch(32'h200));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    waitFetchEmpty(20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Misaligned target halts fetch; an aligned redirect recovers.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("halt_fault", {31'd0, misalign_fault}, 32'd1);
    checkOutput("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("halt_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("halt_pc_kept", imem_req_addr, 32'h204);
    repeat (4) begin
      @(negedge clk);
      checkOutput("halt_idle_req", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("halt_sticky_fault", {31'd0, misalign_fault}, 32'd1);
    end
    tick();
    exp_req.push_back(32'h300);
    exp_fetch.push_back(mkFetch(32'h300));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("recover_fault", {31'd0, misalign_fault}, 32'd0);
    checkOutput("recover_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("recover_req_addr", imem_req_addr, 32'h300);
    waitFetchEmpty(20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // PC wrap at the top of the address space, then reset in the middle of WAIT.
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    exp_fetch.push_back(mkFetch(32'hFFFF_FFFC));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    waitFetchEmpty(20);
    resp_delay = 1;
    waitAccept(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    resp_delay = 0;
    tick();
    @(negedge clk);
    checkOutput("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    exp_req.push_back(32'h0);
    exp_fetch.push_back(mkFetch(32'h0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("postrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("postrst_req_addr", imem_req_addr, 32'h0);
    checkOutput("postrst_fault", {31'd0, misalign_fault}, 32'd0);
    waitFetchEmpty(20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) tick();

    checkOutput("req_queue_left", 32'(exp_req.size()), 32'd0);
    checkOutput("fetch_queue_left", 32'(exp_fetch.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
